// File: rtl/rca8_seq_ctrl_pkg.sv
// rtl/rca8_seq_ctrl_pkg.sv - shared state encoding, defaults and overflow helper
// Purpose: constants common to the sequencer, its bus interface and the bench.
// Ports: none (package).
package rca8_seq_ctrl_pkg;

  localparam int NBYTES_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Signed overflow of a + b' where b' is the (possibly inverted) second operand:
  // like-signed operands producing a result of the other sign.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/rca8_seq_ctrl_if.sv
// rtl/rca8_seq_ctrl_if.sv - start/done request bus between requester and sequencer
// Purpose: bundles the request (start/sub/op_a/op_b) and result (ready/busy/done/sum/cout/ovf).
// Ports: master = requester side, slave = sequencer side.
interface rca8_seq_ctrl_if
  import rca8_seq_ctrl_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, op_a, op_b,
    input  ready, busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output ready, busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/rca8_seq_ctrl_rca8.sv
// rtl/rca8_seq_ctrl_rca8.sv - 8-bit ripple-carry adder, the sequencer's only datapath
// Purpose: s_o = a_i + b_i + c0_i, carry out on c_o.
// Ports: a_i/b_i byte operands, c0_i carry in, s_o byte sum, c_o carry out.
module rca8_seq_ctrl_rca8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c0_i,
  output logic [7:0] s_o,
  output logic       c_o
);

  logic [8:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c0_i;
    for (int i = 0; i < 8; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o = c[8];

endmodule

// File: rtl/rca8_seq_ctrl.sv
// rtl/rca8_seq_ctrl.sv - byte-serial multi-precision add/subtract sequencer
// Purpose: time-shares one rca8 over NBYTES bytes, LSB first, carrying between bytes in a register.
// Ports: clk rising-edge clock, rst_n async active-low reset, bus slave side of rca8_seq_ctrl_if.
module rca8_seq_ctrl
  import rca8_seq_ctrl_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rca8_seq_ctrl_if.slave       bus
);

  localparam int              W    = 8 * NBYTES;
  localparam int              CW   = $clog2(NBYTES);
  localparam logic [CW-1:0]   LAST = CW'(NBYTES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [7:0]    a_byte, b_byte, s_byte;
  logic          c_byte;

  // b_q already holds ~op_b for subtraction, so the adder always adds.
  assign a_byte = a_q[{cnt_q, 3'b000} +: 8];
  assign b_byte = b_q[{cnt_q, 3'b000} +: 8];

  rca8_seq_ctrl_rca8 u_rca8 (
    .a_i  (a_byte),
    .b_i  (b_byte),
    .c0_i (carry_q),
    .s_o  (s_byte),
    .c_o  (c_byte)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          a_d     = bus.op_a;
          b_d     = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d = bus.sub;  // the +1 of A + ~B + 1
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      ST_RUN: begin
        sum_d[{cnt_q, 3'b000} +: 8] = s_byte;
        carry_d = c_byte;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          cout_d  = c_byte;
          ovf_d   = signed_ovf(a_q[W-1], b_q[W-1], s_byte[7]);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule
